// File: rtl/pool_window_buffer.sv
// Pool window builder: keeps the last KERNEL_HEIGHT rows and emits one KERNEL_HEIGHT x KERNEL_WIDTH window per stride step.
// Window valid 1 cycle after its final pixel is accepted; input stalls only while a window is held unaccepted.
module pool_window_buffer #(
    parameter int DATA_IN_0_PRECISION_0 = 8,
    parameter int DATA_IN_0_PRECISION_1 = 3,
    parameter int DATA_IN_0_WIDTH       = 8,
    parameter int DATA_IN_0_HEIGHT      = 8,
    parameter int KERNEL_WIDTH          = 2,
    parameter int KERNEL_HEIGHT         = 2,
    parameter int STRIDE                = 2
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [DATA_IN_0_PRECISION_0-1:0] data_in_0,
    input  logic                             data_in_0_valid,
    output logic                             data_in_0_ready,
    output logic [DATA_IN_0_PRECISION_0-1:0] data_out_0 [KERNEL_HEIGHT*KERNEL_WIDTH],
    output logic                             data_out_0_valid,
    input  logic                             data_out_0_ready
);
    localparam int P  = DATA_IN_0_PRECISION_0;
    localparam int W  = DATA_IN_0_WIDTH;
    localparam int H  = DATA_IN_0_HEIGHT;
    localparam int KW = KERNEL_WIDTH;
    localparam int KH = KERNEL_HEIGHT;
    localparam int S  = STRIDE;
    localparam int NW = KH * KW;
    localparam int CW = (W > 1) ? $clog2(W) : 1;
    localparam int RW = (H > 1) ? $clog2(H) : 1;
    localparam int SW = (KH > 1) ? $clog2(KH) : 1;
    localparam int PW = (S > 1) ? $clog2(S) : 1;

    localparam logic [CW-1:0] COL_LAST  = CW'(W - 1);
    localparam logic [CW-1:0] COL_K     = CW'(KW - 1);
    localparam logic [RW-1:0] ROW_LAST  = RW'(H - 1);
    localparam logic [RW-1:0] ROW_K     = RW'(KH - 1);
    localparam logic [SW-1:0] SLOT_LAST = SW'(KH - 1);
    localparam logic [PW-1:0] PH_LAST   = PW'(S - 1);

    if (KW < 1 || KW > W) begin : g_bad_kw
        $error("KERNEL_WIDTH out of range");
    end
    if (KH < 1 || KH > H) begin : g_bad_kh
        $error("KERNEL_HEIGHT out of range");
    end
    if (S < 1 || S > KW || S > KH) begin : g_bad_stride
        $error("STRIDE out of range");
    end
    if (P < 1 || DATA_IN_0_PRECISION_1 < 0 || DATA_IN_0_PRECISION_1 > P) begin : g_bad_prec
        $error("precision parameters out of range");
    end

    logic [P-1:0]    line_buf [KH][W];
    logic [CW-1:0]   col_cnt;
    logic [RW-1:0]   row_cnt;
    logic [SW-1:0]   slot_cnt;
    logic [PW-1:0]   col_ph;
    logic [PW-1:0]   row_ph;
    logic [SW-1:0]   rd_slot;
    logic [CW-1:0]   rd_col;
    logic [P-1:0]    win_next [NW];
    logic            accept;
    logic            win_done;

    assign data_in_0_ready = !data_out_0_valid || data_out_0_ready;
    assign accept          = data_in_0_valid && data_in_0_ready;
    // Stride phases count only once a full kernel span is covered, so phase 0 marks a window edge.
    assign win_done        = (row_cnt >= ROW_K) && (row_ph == '0) &&
                             (col_cnt >= COL_K) && (col_ph == '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            col_cnt  <= '0;
            row_cnt  <= '0;
            slot_cnt <= '0;
            col_ph   <= '0;
            row_ph   <= '0;
        end else if (accept) begin
            if (col_cnt == COL_LAST) begin
                col_cnt <= '0;
                col_ph  <= '0;
                if (row_cnt == ROW_LAST) begin
                    row_cnt  <= '0;
                    slot_cnt <= '0;
                    row_ph   <= '0;
                end else begin
                    row_cnt  <= row_cnt + 1'b1;
                    slot_cnt <= (slot_cnt == SLOT_LAST) ? '0 : slot_cnt + 1'b1;
                    if (row_cnt >= ROW_K) begin
                        row_ph <= (row_ph == PH_LAST) ? '0 : row_ph + 1'b1;
                    end
                end
            end else begin
                col_cnt <= col_cnt + 1'b1;
                if (col_cnt >= COL_K) begin
                    col_ph <= (col_ph == PH_LAST) ? '0 : col_ph + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            line_buf[slot_cnt][col_cnt] <= data_in_0;
        end
    end

    // Oldest window row lives in the slot after the one being written; the last element is the live pixel.
    always_comb begin
        rd_slot  = '0;
        rd_col   = '0;
        win_next = '{default: '0};
        for (int m = 0; m < KH; m++) begin
            for (int n = 0; n < KW; n++) begin
                rd_slot = SW'((int'(slot_cnt) + 1 + m) % KH);
                rd_col  = CW'(int'(col_cnt) - (KW - 1) + n);
                win_next[m*KW+n] = line_buf[rd_slot][rd_col];
            end
        end
        win_next[NW-1] = data_in_0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_out_0_valid <= 1'b0;
            data_out_0       <= '{default: '0};
        end else if (accept && win_done) begin
            data_out_0_valid <= 1'b1;
            data_out_0       <= win_next;
        end else if (data_out_0_ready) begin
            data_out_0_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_pool_window_buffer.sv
// Directed bench for pool_window_buffer: three geometries, stalls, back-to-back frames and mid-frame reset.
module tb_pool_window_buffer;
    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] din;
    logic [2:0] in_vld;
    logic       out_rdy;
    logic       in_rdy0, in_rdy1, in_rdy2;
    logic       ov0, ov1, ov2;
    logic [7:0] do0 [4];
    logic [7:0] do1 [9];
    logic [7:0] do2 [4];
    int         sel;

    logic       ob_vld;
    logic       ob_in_rdy;
    logic [7:0] ob_win [9];

    int total = 0;
    int bad   = 0;
    int win_q[$];
    int nwin;
    int first_vld_cyc;
    int acc9_cyc;
    int rdy_drops;
    int stall_seen;
    int e [9];

    always #5 clk = ~clk;

    pool_window_buffer u0 (
        .clk(clk), .rst(rst), .data_in_0(din), .data_in_0_valid(in_vld[0]),
        .data_in_0_ready(in_rdy0), .data_out_0(do0), .data_out_0_valid(ov0),
        .data_out_0_ready(out_rdy)
    );

    pool_window_buffer #(
        .DATA_IN_0_WIDTH(4), .DATA_IN_0_HEIGHT(4), .KERNEL_WIDTH(3), .KERNEL_HEIGHT(3), .STRIDE(1)
    ) u1 (
        .clk(clk), .rst(rst), .data_in_0(din), .data_in_0_valid(in_vld[1]),
        .data_in_0_ready(in_rdy1), .data_out_0(do1), .data_out_0_valid(ov1),
        .data_out_0_ready(out_rdy)
    );

    pool_window_buffer #(
        .DATA_IN_0_WIDTH(5), .DATA_IN_0_HEIGHT(5)
    ) u2 (
        .clk(clk), .rst(rst), .data_in_0(din), .data_in_0_valid(in_vld[2]),
        .data_in_0_ready(in_rdy2), .data_out_0(do2), .data_out_0_valid(ov2),
        .data_out_0_ready(out_rdy)
    );

    always_comb begin
        ob_vld    = ov0;
        ob_in_rdy = in_rdy0;
        ob_win    = '{default: '0};
        case (sel)
            1: begin
                ob_vld    = ov1;
                ob_in_rdy = in_rdy1;
                for (int i = 0; i < 9; i++) ob_win[i] = do1[i];
            end
            2: begin
                ob_vld    = ov2;
                ob_in_rdy = in_rdy2;
                for (int i = 0; i < 4; i++) ob_win[i] = do2[i];
            end
            default: begin
                for (int i = 0; i < 4; i++) ob_win[i] = do0[i];
            end
        endcase
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Streams npix pixels (value = frame*100 + raster index) into instance s and records every transferred window.
    task automatic run(input int s, input int w, input int h, input int nel,
                       input int npix, input bit drain, input int stall_len);
        int         sent = 0;
        int         cyc = 0;
        int         pix;
        int         f;
        logic       s_vld;
        logic       s_in_rdy;
        logic [7:0] s_win [9];
        sel = s;
        win_q.delete();
        nwin = 0;
        first_vld_cyc = -1;
        acc9_cyc = -1;
        rdy_drops = 0;
        stall_seen = 0;
        s_vld = ob_vld;
        while ((sent < npix || (drain && s_vld)) && cyc < 3000) begin
            @(negedge clk);
            f   = sent / (w * h);
            pix = sent % (w * h);
            din = 8'(f * 100 + pix);
            in_vld = '0;
            if (sent < npix) in_vld[s] = 1'b1;
            if (stall_len > 0 && ob_vld && nwin == 0 && stall_seen < stall_len) begin
                out_rdy = 1'b0;
                stall_seen++;
            end else begin
                out_rdy = 1'b1;
            end
            #1;
            s_vld    = ob_vld;
            s_in_rdy = ob_in_rdy;
            s_win    = ob_win;
            if (!out_rdy) begin
                check("stall_w0", s_win[0], 0);
                check("stall_w1", s_win[1], 1);
                check("stall_w2", s_win[2], 8);
                check("stall_w3", s_win[3], 9);
                check("stall_in_ready", s_in_rdy, 0);
            end else if (!s_in_rdy) begin
                rdy_drops++;
            end
            if (s_vld && first_vld_cyc < 0) first_vld_cyc = cyc;
            @(posedge clk);
            if (s_vld && out_rdy) begin
                for (int i = 0; i < nel; i++) win_q.push_back(int'(s_win[i]));
                nwin++;
            end
            if (in_vld[s] && s_in_rdy) begin
                if (sent == 9) acc9_cyc = cyc;
                sent++;
            end
            cyc++;
            #1;
            s_vld = ob_vld;
        end
        in_vld = '0;
        check("run_timeout", cyc < 3000, 1);
    endtask

    // Reference windows straight from the definition: element m*kw+n is pixel (oy*st+m, ox*st+n).
    task automatic check_frames(input string tag, input int w, input int h, input int kh,
                                input int kw, input int st, input int nf);
        int ow = (w - kw) / st + 1;
        int oh = (h - kh) / st + 1;
        int k = 0;
        int got;
        check({tag, "_count"}, nwin, nf * ow * oh);
        for (int f = 0; f < nf; f++)
            for (int oy = 0; oy < oh; oy++)
                for (int ox = 0; ox < ow; ox++)
                    for (int m = 0; m < kh; m++)
                        for (int n = 0; n < kw; n++) begin
                            got = (k < win_q.size()) ? win_q[k] : -1;
                            check(tag, got, f * 100 + (oy * st + m) * w + ox * st + n);
                            k++;
                        end
    endtask

    task automatic check_win(input string tag, input int idx, input int n, input int ex [9]);
        int pos;
        for (int i = 0; i < n; i++) begin
            pos = idx * n + i;
            check(tag, (pos < win_q.size()) ? win_q[pos] : -1, ex[i]);
        end
    endtask

    initial begin
        rst = 1'b0;
        din = '0;
        in_vld = '0;
        out_rdy = 1'b1;
        sel = 0;
        repeat (2) @(negedge clk);
        #1;
        check("reset_valid", ov0, 0);
        check("reset_data0", do0[0], 0);
        check("reset_data3", do0[3], 0);
        check("reset_in_ready", in_rdy0, 1);
        rst = 1'b1;

        // 8x8, 2x2, stride 2, free-flowing output
        run(0, 8, 8, 4, 64, 1'b1, 0);
        check_frames("f8", 8, 8, 2, 2, 2, 1);
        e = '{0, 1, 8, 9, 0, 0, 0, 0, 0};
        check_win("f8_first", 0, 4, e);
        e = '{2, 3, 10, 11, 0, 0, 0, 0, 0};
        check_win("f8_second", 1, 4, e);
        e = '{54, 55, 62, 63, 0, 0, 0, 0, 0};
        check_win("f8_last", 15, 4, e);
        check("f8_acc9_cycle", acc9_cyc, 9);
        check("f8_latency", first_vld_cyc, acc9_cyc + 1);
        check("f8_ready_drops", rdy_drops, 0);

        // Same frame, output held off for 5 cycles on the first window
        run(0, 8, 8, 4, 64, 1'b1, 5);
        check("stall_cycles", stall_seen, 5);
        check("stall_ready_drops", rdy_drops, 0);
        check_frames("f8_stall", 8, 8, 2, 2, 2, 1);

        // 4x4, 3x3, stride 1
        run(1, 4, 4, 9, 16, 1'b1, 0);
        check("k3_count", nwin, 4);
        e = '{0, 1, 2, 4, 5, 6, 8, 9, 10};
        check_win("k3_w0", 0, 9, e);
        e = '{1, 2, 3, 5, 6, 7, 9, 10, 11};
        check_win("k3_w1", 1, 9, e);
        e = '{4, 5, 6, 8, 9, 10, 12, 13, 14};
        check_win("k3_w2", 2, 9, e);
        e = '{5, 6, 7, 9, 10, 11, 13, 14, 15};
        check_win("k3_w3", 3, 9, e);

        // 5x5, 2x2, stride 2: row 4 and column 4 fall outside every window
        run(2, 5, 5, 4, 25, 1'b1, 0);
        check("f5_count", nwin, 4);
        e = '{0, 1, 5, 6, 0, 0, 0, 0, 0};
        check_win("f5_w0", 0, 4, e);
        e = '{2, 3, 7, 8, 0, 0, 0, 0, 0};
        check_win("f5_w1", 1, 4, e);
        e = '{10, 11, 15, 16, 0, 0, 0, 0, 0};
        check_win("f5_w2", 2, 4, e);
        e = '{12, 13, 17, 18, 0, 0, 0, 0, 0};
        check_win("f5_w3", 3, 4, e);

        // Two back-to-back 8x8 frames
        run(0, 8, 8, 4, 128, 1'b1, 0);
        check_frames("f8x2", 8, 8, 2, 2, 2, 2);
        e = '{100, 101, 108, 109, 0, 0, 0, 0, 0};
        check_win("f8x2_w16", 16, 4, e);
        check("f8x2_ready_drops", rdy_drops, 0);

        // Partial frame through pixel 25 leaves a window pending, then an asynchronous reset mid-cycle
        run(0, 8, 8, 4, 26, 1'b0, 0);
        @(negedge clk);
        out_rdy = 1'b0;
        #1;
        check("pend_valid", ob_vld, 1);
        check("pend_in_ready", ob_in_rdy, 0);
        rst = 1'b0;
        #1;
        check("arst_valid", ov0, 0);
        check("arst_data0", do0[0], 0);
        check("arst_in_ready", in_rdy0, 1);
        @(negedge clk);
        rst = 1'b1;
        out_rdy = 1'b1;
        run(0, 8, 8, 4, 64, 1'b1, 0);
        check_frames("post_rst", 8, 8, 2, 2, 2, 1);
        e = '{0, 1, 8, 9, 0, 0, 0, 0, 0};
        check_win("post_rst_first", 0, 4, e);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
